// File: rtl/mult_pkg.sv
// Shared types and limits for the pipelined integer multiplier.
package mult_pkg;

    // Per-operation mode: operand signedness and which product half to return.
    typedef struct packed {
        logic a_signed;
        logic b_signed;
        logic high;
    } mult_mode_t;

    // Product capture needs at least one register stage.
    localparam int MULT_MIN_STAGES = 1;

endpackage

// File: rtl/mult_pipe_stage.sv
// One valid/ready register stage. Loads whenever it is empty or its
// contents are leaving, so bubbles ahead of a stall get squeezed out.
module mult_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Capture on advance; payload only changes when a valid item arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/pipelined_mult_unit.sv
// Fully pipelined integer multiplier with valid/ready on both sides,
// per-op signedness, half select and a pass-through tag. The product is
// formed combinationally ahead of stage 0; later stages are plain delay
// registers that retiming can pull the multiplier into.
module pipelined_mult_unit
    import mult_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 3,
    parameter int TAG_LEN        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_a,
    input  logic [DATA_LEN-1:0] in_b,
    input  logic                in_a_signed,
    input  logic                in_b_signed,
    input  logic                in_high,
    input  logic [TAG_LEN-1:0]  in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_result,
    output logic [TAG_LEN-1:0]  out_tag,
    output logic                busy
);

    if (PIPELINE_STAGE < MULT_MIN_STAGES) begin : g_bad_stages
        $error("pipelined_mult_unit: PIPELINE_STAGE must be >= %0d", MULT_MIN_STAGES);
    end

    localparam int PW = DATA_LEN + TAG_LEN;

    typedef struct packed {
        logic [DATA_LEN-1:0] result;
        logic [TAG_LEN-1:0]  tag;
    } payload_t;

    mult_mode_t            mode;
    logic [2*DATA_LEN-1:0] a_ext, b_ext, product;
    payload_t              in_pl, out_pl;

    // vld_pipe[i+1] / dat_pipe[i+1] are the outputs of stage i.
    logic [PIPELINE_STAGE:0]         vld_pipe;
    logic [PIPELINE_STAGE:0][PW-1:0] dat_pipe;
    logic [PIPELINE_STAGE-1:0]       down_rdy;
    logic [PIPELINE_STAGE-1:0]       stage_rdy;
    logic                            unused_stage_rdy;

    // Extend both operands to the full product width, then keep the low
    // 2*DATA_LEN bits of the product, which are exact for any signedness mix.
    always_comb begin
        mode.a_signed = in_a_signed;
        mode.b_signed = in_b_signed;
        mode.high     = in_high;
        a_ext   = {{DATA_LEN{mode.a_signed & in_a[DATA_LEN-1]}}, in_a};
        b_ext   = {{DATA_LEN{mode.b_signed & in_b[DATA_LEN-1]}}, in_b};
        product = a_ext * b_ext;
        in_pl.result = mode.high ? product[2*DATA_LEN-1:DATA_LEN] : product[DATA_LEN-1:0];
        in_pl.tag    = in_tag;
    end

    // Downstream-ready per stage, built from valid bits only so the ready
    // chain never feeds back through a single vector.
    always_comb begin : p_down_rdy
        logic r;
        r = out_ready;
        for (int i = PIPELINE_STAGE - 1; i >= 0; i--) begin
            down_rdy[i] = r;
            r = !vld_pipe[i+1] || r;
        end
    end

    assign vld_pipe[0] = in_valid;
    assign dat_pipe[0] = in_pl;

    for (genvar i = 0; i < PIPELINE_STAGE; i++) begin : g_stage
        mult_pipe_stage #(.WIDTH(PW)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (vld_pipe[i]),
            .in_ready  (stage_rdy[i]),
            .in_data   (dat_pipe[i]),
            .out_valid (vld_pipe[i+1]),
            .out_ready (down_rdy[i]),
            .out_data  (dat_pipe[i+1])
        );
    end

    // Inner stage readies duplicate down_rdy; only stage 0 faces the producer.
    assign unused_stage_rdy = &stage_rdy;

    assign in_ready   = stage_rdy[0] && !reset;
    assign out_pl     = dat_pipe[PIPELINE_STAGE];
    assign out_valid  = vld_pipe[PIPELINE_STAGE];
    assign out_result = out_pl.result;
    assign out_tag    = out_pl.tag;
    assign busy       = |vld_pipe[PIPELINE_STAGE:1];

endmodule

// File: tb/tb_pipelined_mult_unit.sv
// Bench for pipelined_mult_unit: table-driven vectors plus hand-written
// stall, bubble and reset sequences, all checked through a scoreboard.
module tb_pipelined_mult_unit;

    localparam int DL = 32;
    localparam int PS = 3;
    localparam int TL = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DL-1:0] in_a = '0, in_b = '0;
    logic          in_a_signed = 1'b0, in_b_signed = 1'b0, in_high = 1'b0;
    logic [TL-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DL-1:0] out_result;
    logic [TL-1:0] out_tag;
    logic          busy;

    pipelined_mult_unit #(.DATA_LEN(DL), .PIPELINE_STAGE(PS), .TAG_LEN(TL)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_a_signed (in_a_signed),
        .in_b_signed (in_b_signed),
        .in_high     (in_high),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DL-1:0] res;
        logic [TL-1:0] tag;
        int            acc_cyc;
        bit            lat;
    } sb_t;

    typedef struct {
        logic [DL-1:0] a, b;
        logic          as, bs, hi;
        logic [TL-1:0] tag;
        logic [DL-1:0] exp;
    } vec_t;

    sb_t           sb_q[$];
    vec_t          vt[8];
    int            n_cmp = 0, n_err = 0, cyc = 0;
    bit            lat_chk = 1'b0;
    logic [DL-1:0] drv_exp = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin : p_mon
        sb_t e;
        cyc++;
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stale_output: got result 0x%0h tag 0x%0h with nothing outstanding", out_result, out_tag);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result", out_result, e.res);
                    check("sb_tag", out_tag, e.tag);
                    if (e.lat) check("latency", cyc - e.acc_cyc, PS);
                end
            end
            if (in_valid && in_ready) begin
                e.res = drv_exp; e.tag = in_tag; e.acc_cyc = cyc; e.lat = lat_chk;
                sb_q.push_back(e);
            end
        end
    end

    task automatic set_op(input logic [DL-1:0] a, b, input logic as, bs, hi,
                          input logic [TL-1:0] tag, input logic [DL-1:0] exp);
        in_valid = 1'b1; in_a = a; in_b = b;
        in_a_signed = as; in_b_signed = bs; in_high = hi;
        in_tag = tag; drv_exp = exp;
    endtask

    // Offer one op and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [DL-1:0] a, b, input logic as, bs, hi,
                        input logic [TL-1:0] tag, input logic [DL-1:0] exp);
        int n;
        set_op(a, b, as, bs, hi, tag, exp);
        n = 0;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 50) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: in_ready 0, required 1 within 50 cycles");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, acc;
        bit rdy_seen, have;
        logic [DL-1:0] hold_res;
        logic [TL-1:0] hold_tag;

        vt[0] = '{32'hFFFF_FFFD, 32'd7,        1, 1, 0, 8'h11, 32'hFFFF_FFEB};
        vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 8'h21, 32'hFFFF_FFFE};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 8'h22, 32'h0000_0000};
        vt[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 8'h23, 32'hFFFF_FFFF};
        vt[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 8'h24, 32'h0000_0001};
        vt[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 0, 8'h25, 32'h8000_0000};
        vt[6] = '{32'hFFFF_FFFF, 32'd2,        0, 0, 1, 8'h26, 32'h0000_0001};
        vt[7] = '{32'h1234_5678, 32'h10,       0, 0, 0, 8'h27, 32'h2345_6780};

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Table vectors, one at a time, exact latency checked
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vt[i].a, vt[i].b, vt[i].as, vt[i].bs, vt[i].hi, vt[i].tag, vt[i].exp);
            drain();
        end

        // Throughput: 10 back-to-back ops
        for (int i = 0; i < 10; i++)
            send(i, i + 1, 0, 0, 0, i[TL-1:0], i * (i + 1));
        drain();

        // Backpressure: continuous offer with the consumer stalled
        lat_chk = 1'b0;
        out_ready = 1'b0;
        k = 0; acc = 0; have = 1'b0;
        hold_res = '0; hold_tag = '0;
        set_op(100 + k, 3, 0, 0, 0, 8'h40 + k[TL-1:0], (100 + k) * 3);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rdy_seen = in_ready;
            if (rdy_seen) acc++;
            if (out_valid) begin
                if (!have) begin
                    hold_res = out_result; hold_tag = out_tag; have = 1'b1;
                end else begin
                    check("bp_stable_result", out_result, hold_res);
                    check("bp_stable_tag", out_tag, hold_tag);
                end
            end
            @(posedge clk); #1;
            if (rdy_seen) begin
                k++;
                set_op(100 + k, 3, 0, 0, 0, 8'h40 + k[TL-1:0], (100 + k) * 3);
            end
        end
        in_valid = 1'b0;
        check("bp_accepts", acc, 3);
        check("bp_first_result", hold_res, 32'd300);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Bubble collapse: a single held op must not block further accepts
        out_ready = 1'b0;
        send(7, 6, 0, 0, 0, 8'h50, 42);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bub_in_ready", in_ready, 1);
        check("bub_busy", busy, 1);
        @(posedge clk); #1;
        send(8, 6, 0, 0, 0, 8'h51, 48);
        send(9, 6, 0, 0, 0, 8'h52, 54);
        @(negedge clk);
        check("bub_full_in_ready", in_ready, 0);
        check("bub_full_busy", busy, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("bub_idle_busy", busy, 0);
        @(posedge clk); #1;

        // Reset mid-flight: in-flight ops vanish
        send(5, 5, 0, 0, 0, 8'h60, 25);
        send(6, 6, 0, 0, 0, 8'h61, 36);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_out_valid", out_valid, 0);
        check("mid_out_result", out_result, 0);
        check("mid_out_tag", out_tag, 0);
        check("mid_busy", busy, 0);
        check("mid_in_ready", in_ready, 1);
        repeat (6) @(negedge clk);
        check("mid_quiet", out_valid, 0);
        @(posedge clk); #1;

        // Recovery after reset
        lat_chk = 1'b1;
        send(32'hFFFF_FFFE, 32'd3, 1, 0, 1, 8'h70, 32'hFFFF_FFFF);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_mult_unit.md
# pipelined_mult_unit

Parametrised, fully pipelined integer multiplier with valid/ready handshakes on both sides, per-operation signedness and half-product selection, and an opaque tag carried alongside each operation. It replaces the fixed 32-bit, fixed-latency, always-enabled multiplier in the arithmetic datapath next to the divider. Downstream logic may stall it without losing or duplicating results.

## Interface
- DATA_LEN, 32, operand and result width
- PIPELINE_STAGE, 3, number of register stages (>= 1); equals no-stall latency
- TAG_LEN, 8, width of the pass-through tag (>= 1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted this cycle when in_valid && in_ready
- in_a  in  DATA_LEN  operand A
- in_b  in  DATA_LEN  operand B
- in_a_signed  in  1  treat A as two's complement
- in_b_signed  in  1  treat B as two's complement
- in_high  in  1  1: return product[2*DATA_LEN-1:DATA_LEN]; 0: return product[DATA_LEN-1:0]
- in_tag  in  TAG_LEN  opaque, returned with the result
- out_valid  out  1  result presented
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_result  out  DATA_LEN  selected product half
- out_tag  out  TAG_LEN  tag of the presented result
- busy  out  1  any stage holds a valid operation

## Operation
- Arithmetic: each operand extended to DATA_LEN+1 bits (sign-extended if its signed flag is set, else zero-extended); full 2*DATA_LEN product formed; in_high selects the half. Overflow is not flagged.
- Product is formed combinationally from accepted inputs and captured in stage 0. Stages 1..PIPELINE_STAGE-1 are delay registers. Synthesis retiming spreads the multiplier.
- Each stage i holds valid[i], a result, and a tag. Stage PIPELINE_STAGE-1 drives out_*.
- Advance rule (bubble-collapsing):
  - The last stage advances when !out_valid || out_ready.
  - Stage i advances when !valid[i+1] || advance[i+1].
  - in_ready = !valid[0] || advance[0].
- A stage that does not advance holds its contents unchanged. A stage whose contents move on and receives nothing clears its valid.
- Results leave in acceptance order. Each accepted operation produces exactly one output handshake.
- busy = OR of all valid[i].

## Timing
- Reset:
  - All valid bits clear. out_valid = 0, out_result = 0, out_tag = 0, busy = 0.
  - in_ready = 0 while reset is high. in_ready = 1 in the first cycle after reset is deasserted.
- Latency: an operation accepted at edge N with no stall gives out_valid = 1 in the cycle after edge N+PIPELINE_STAGE-1, i.e. PIPELINE_STAGE cycles.
- Throughput: 1 operation per cycle while out_ready = 1.
- Stall: while out_ready = 0, out_result and out_tag stay stable and out_valid stays asserted. Bubbles ahead of the stall keep filling.
  - in_ready falls once all PIPELINE_STAGE stages are valid and the last stage cannot advance.
  - in_ready combinationally depends on out_ready; no combinational path from in_valid to in_ready.
- Simultaneous accept and output on a full pipeline proceeds without a bubble.
- Reset mid-operation: all in-flight operations are discarded. No output handshake occurs for them.

## Structure
- Package mult_pkg holds:
  - typedef mult_mode_t, a packed struct {a_signed, b_signed, high}
  - constant MULT_MIN_STAGES = 1
  - an elaboration check against PIPELINE_STAGE < MULT_MIN_STAGES
- One sub-module, mult_pipe_stage: a single valid/ready register stage, parametrised on payload width. Instantiate it PIPELINE_STAGE times with a generate loop. The product computation and result selection stay in the top level.

## Test plan
All scenarios use DATA_LEN=32, PIPELINE_STAGE=3.
- Signed low half: a=0xFFFFFFFD, b=7, both signed, high=0, tag=0x11 -> out_result=0xFFFFFFEB, out_tag=0x11, exactly 3 cycles after accept.
- Mode matrix with a=b=0xFFFFFFFF and high=1:
  - unsigned/unsigned -> 0xFFFFFFFE
  - signed/signed -> 0x00000000
  - signed/unsigned -> 0xFFFFFFFF
  - signed/signed with high=0 -> 0x00000001
- Throughput: 10 back-to-back ops (a=i, b=i+1, tag=i), out_ready=1 -> results i*(i+1) on 10 consecutive cycles, starting 3 cycles after the first accept, tags 0..9 in order.
- Backpressure: continuous input with out_ready=0 for 6 cycles -> exactly 3 accepts, then in_ready=0; out_result/out_tag stable. After release, every op appears once, in order, no gaps.
- Bubble collapse: 1 op, out_ready=0 -> in_ready stays 1 until 3 ops are held; busy=1 throughout; busy=0 after the last handshake.
- Reset mid-flight: 2 ops accepted, then reset for 1 cycle -> out_valid=0, out_result=0, busy=0. in_ready=1 the cycle after reset. No stale result is ever emitted.
